// File: rtl/cfi_alert_sched.sv
`default_nettype none
// ============================================================================
// Module      : cfi_alert_sched
// Description : Collects per-commit-port CFI events (JALR commits and, when
//               CFI_SLED_DETECT_EN is defined, NOP-sled detections). Events
//               are queued in program order in a small FIFO and sent one at a
//               time on a valid/ready alert channel. Events that do not fit
//               in the FIFO are dropped and counted.
//               Optional feature macro: CFI_SLED_DETECT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cfi_alert_sched #(
    parameter int NR_PORTS        = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int NOP_SLED_THRESH = 8,
    parameter int PC_W            = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NR_PORTS-1:0]      commit_ack_i,
    input  logic [NR_PORTS-1:0]      jalr_det_i,
    input  logic [NR_PORTS-1:0]      nop_det_i,
    input  logic [NR_PORTS*PC_W-1:0] pc_i,
    input  logic                     flush_i,
    input  logic                     ovf_clr_i,
    output logic                     alert_valid_o,
    input  logic                     alert_ready_i,
    output logic [1:0]               alert_type_o,
    output logic                     alert_port_o,
    output logic [PC_W-1:0]          alert_pc_o,
    output logic [7:0]               sled_cnt_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int         c_AW        = $clog2(FIFO_DEPTH);
    localparam int         c_CW        = c_AW + 1;
    // Two candidate events per port: even slot = JALR, odd slot = sled.
    // Slot order is therefore the enqueue order (JALR before sled).
    localparam int         c_NSLOT     = 2 * NR_PORTS;
    localparam logic [1:0] c_TYPE_JALR = 2'b01;
    localparam logic [1:0] c_TYPE_SLED = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FIFO storage and pointers
    logic [1:0]      r_fifo_type [FIFO_DEPTH];
    logic            r_fifo_port [FIFO_DEPTH];
    logic [PC_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    // Output payload register
    logic [1:0]      r_out_type;
    logic            r_out_port;
    logic [PC_W-1:0] r_out_pc;

    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    // Per-slot candidate events and their write placement
    logic [c_NSLOT-1:0] w_ev_vld;
    logic [1:0]         w_ev_type [c_NSLOT];
    logic               w_ev_port [c_NSLOT];
    logic [PC_W-1:0]    w_ev_pc   [c_NSLOT];
    logic [c_NSLOT-1:0] w_wr_en;
    logic [c_AW-1:0]    w_wr_addr [c_NSLOT];
    logic [c_CW-1:0]    w_n_wr;
    logic [7:0]         w_n_drop;
    logic [7:0]         w_drop_sum;
    logic               w_fifo_empty;
    logic               w_pop;

`ifdef CFI_SLED_DETECT_EN
    localparam logic [7:0] c_THRESH = 8'(NOP_SLED_THRESH);
    logic [7:0] r_sled_cnt;
    logic [7:0] w_sled_nxt;
`else
    logic w_unused_nop;
    assign w_unused_nop = ^nop_det_i;
`endif

    // Build the candidate event list; the sled counter walks ports oldest first
    always_comb begin
        w_ev_vld = '0;
`ifdef CFI_SLED_DETECT_EN
        w_sled_nxt = r_sled_cnt;
`endif
        for (int p = 0; p < NR_PORTS; p++) begin
            w_ev_type[2*p]   = c_TYPE_JALR;
            w_ev_type[2*p+1] = c_TYPE_SLED;
            w_ev_port[2*p]   = 1'(p);
            w_ev_port[2*p+1] = 1'(p);
            w_ev_pc[2*p]     = pc_i[p*PC_W +: PC_W];
            w_ev_pc[2*p+1]   = pc_i[p*PC_W +: PC_W];
            w_ev_vld[2*p]    = commit_ack_i[p] & jalr_det_i[p];
`ifdef CFI_SLED_DETECT_EN
            if (commit_ack_i[p]) begin
                if (nop_det_i[p]) begin
                    // A saturated counter never moves, so the threshold is
                    // crossed at most once until the counter returns to 0.
                    if (w_sled_nxt != 8'hFF) begin
                        w_sled_nxt = w_sled_nxt + 8'd1;
                        if (w_sled_nxt == c_THRESH) begin
                            w_ev_vld[2*p+1] = 1'b1;
                        end
                    end
                end else begin
                    w_sled_nxt = 8'd0;
                end
            end
`endif
        end
    end

    assign w_fifo_empty = (r_count == '0);
    // Head is popped whenever the output register is free or being accepted
    assign w_pop = !flush_i && !w_fifo_empty &&
                   ((r_state == S_IDLE) || alert_ready_i);

    // Pack valid events into the free FIFO slots; the youngest overflow is dropped
    always_comb begin
        int v_cap;
        int v_idx;
        int v_drop;
        v_cap   = FIFO_DEPTH - int'(r_count) + (w_pop ? 1 : 0);
        v_idx   = 0;
        v_drop  = 0;
        w_wr_en = '0;
        for (int s = 0; s < c_NSLOT; s++) begin
            w_wr_addr[s] = r_wptr;
            if (w_ev_vld[s] && !flush_i) begin
                if (v_idx < v_cap) begin
                    w_wr_en[s]   = 1'b1;
                    w_wr_addr[s] = r_wptr + c_AW'(v_idx);
                    v_idx        = v_idx + 1;
                end else begin
                    v_drop = v_drop + 1;
                end
            end
        end
        w_n_wr   = c_CW'(v_idx);
        w_n_drop = 8'(v_drop);
    end

    // Saturating drop total; a same-cycle clear restarts from zero
    always_comb begin
        logic [8:0] v_sum;
        v_sum = {1'b0, (ovf_clr_i ? 8'd0 : r_drop_cnt)} + {1'b0, w_n_drop};
        w_drop_sum = v_sum[8] ? 8'hFF : v_sum[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + w_n_wr[c_AW-1:0];
            r_rptr  <= r_rptr + c_AW'(w_pop);
            r_count <= r_count + w_n_wr - c_CW'(w_pop);
        end
    end

    // FIFO storage writes (payload only, no reset needed)
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < c_NSLOT; s++) begin
            if (w_wr_en[s]) begin
                r_fifo_type[w_wr_addr[s]] <= w_ev_type[s];
                r_fifo_port[w_wr_addr[s]] <= w_ev_port[s];
                r_fifo_pc[w_wr_addr[s]]   <= w_ev_pc[s];
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM next state
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (!w_fifo_empty) w_state_nxt = S_SEND;
                S_SEND: if (alert_ready_i && w_fifo_empty) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output payload register, loaded on every head pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_type <= '0;
            r_out_port <= 1'b0;
            r_out_pc   <= '0;
        end else if (w_pop) begin
            r_out_type <= r_fifo_type[r_rptr];
            r_out_port <= r_fifo_port[r_rptr];
            r_out_pc   <= r_fifo_pc[r_rptr];
        end
    end

    // Sticky overflow and drop counter; a drop beats a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_n_drop != 8'd0) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum;
        end else if (ovf_clr_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

`ifdef CFI_SLED_DETECT_EN
    // Consecutive-NOP counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sled_cnt <= '0;
        end else if (flush_i) begin
            r_sled_cnt <= '0;
        end else begin
            r_sled_cnt <= w_sled_nxt;
        end
    end
    assign sled_cnt_o = r_sled_cnt;
`else
    assign sled_cnt_o = 8'd0;
`endif

    assign alert_valid_o = (r_state == S_SEND);
    assign alert_type_o  = r_out_type;
    assign alert_port_o  = r_out_port;
    assign alert_pc_o    = r_out_pc;
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cfi_alert_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfi_alert_sched
// Description : Directed, table-driven bench for cfi_alert_sched. Each row
//               drives one cycle of inputs and lists the outputs expected
//               just after the following rising edge. Honours
//               CFI_SLED_DETECT_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfi_alert_sched;

`ifdef CFI_SLED_DETECT_EN
    localparam int SL = 1;
`else
    localparam int SL = 0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  commit_ack;
    logic [1:0]  jalr_det;
    logic [1:0]  nop_det;
    logic [127:0] pc;
    logic        flush;
    logic        ovf_clr;
    logic        alert_valid;
    logic        alert_ready;
    logic [1:0]  alert_type;
    logic        alert_port;
    logic [63:0] alert_pc;
    logic [7:0]  sled_cnt;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    cfi_alert_sched #(
        .NR_PORTS(2), .FIFO_DEPTH(4), .NOP_SLED_THRESH(8), .PC_W(64)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .commit_ack_i(commit_ack), .jalr_det_i(jalr_det), .nop_det_i(nop_det),
        .pc_i(pc), .flush_i(flush), .ovf_clr_i(ovf_clr),
        .alert_valid_o(alert_valid), .alert_ready_i(alert_ready),
        .alert_type_o(alert_type), .alert_port_o(alert_port),
        .alert_pc_o(alert_pc), .sled_cnt_o(sled_cnt),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ack, jalr, nop;
        logic [63:0] pc0, pc1;
        logic        fl, clr, rdy;
        logic        ev;
        logic [1:0]  et;
        logic        ep;
        logic [63:0] epc;
        logic        eov;
        logic [7:0]  edc, esc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] ack, input logic [1:0] jalr, input logic [1:0] nop,
        input logic [63:0] pc0, input logic [63:0] pc1,
        input logic fl, input logic clr, input logic rdy,
        input logic ev, input logic [1:0] et, input logic ep, input logic [63:0] epc,
        input logic eov, input logic [7:0] edc, input logic [7:0] esc);
        vec_t v;
        v.ack = ack; v.jalr = jalr; v.nop = nop; v.pc0 = pc0; v.pc1 = pc1;
        v.fl = fl; v.clr = clr; v.rdy = rdy; v.ev = ev; v.et = et; v.ep = ep;
        v.epc = epc; v.eov = eov; v.edc = edc; v.esc = esc;
        return v;
    endfunction

    // Expected sled count: only meaningful when the feature is built in
    function automatic logic [7:0] sc(input int x);
        return (SL != 0) ? 8'(x) : 8'd0;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v, input int row);
        commit_ack  = v.ack;
        jalr_det    = v.jalr;
        nop_det     = v.nop;
        pc          = {v.pc1, v.pc0};
        flush       = v.fl;
        ovf_clr     = v.clr;
        alert_ready = v.rdy;
        @(posedge clk);
        #1;
        chk("valid", row, 64'(alert_valid), 64'(v.ev));
        chk("overflow", row, 64'(overflow), 64'(v.eov));
        chk("drop_cnt", row, 64'(drop_cnt), 64'(v.edc));
        chk("sled_cnt", row, 64'(sled_cnt), 64'(v.esc));
        if (v.ev) begin
            chk("type", row, 64'(alert_type), 64'(v.et));
            chk("port", row, 64'(alert_port), 64'(v.ep));
            chk("pc", row, alert_pc, v.epc);
        end
    endtask

    task automatic chk_all_zero(input int row);
        chk("rst_valid", row, 64'(alert_valid), 64'd0);
        chk("rst_type", row, 64'(alert_type), 64'd0);
        chk("rst_port", row, 64'(alert_port), 64'd0);
        chk("rst_pc", row, alert_pc, 64'd0);
        chk("rst_overflow", row, 64'(overflow), 64'd0);
        chk("rst_drop_cnt", row, 64'(drop_cnt), 64'd0);
        chk("rst_sled_cnt", row, 64'(sled_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        commit_ack = '0; jalr_det = '0; nop_det = '0; pc = '0;
        flush = 1'b0; ovf_clr = 1'b0; alert_ready = 1'b0;

        //            ack   jalr  nop   pc0            pc1      fl  clr rdy  ev et     ep  epc             ov  dc  sc
        // Single JALR latency
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 64'h8000_0010, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 0, 64'h8000_0010, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        // Dual JALR held off by ready=0 for 5 cycles, then back-to-back
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'h100, 64'h104, 0, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 0, 1, 2'b01, 0, 64'h100, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 1, 64'h104, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        // Overflow: three dual JALR cycles into a depth-4 FIFO with ready=0
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hA00, 64'hA04, 0, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hA10, 64'hA14, 0, 0, 0, 1, 2'b01, 0, 64'hA00, 0, 0, sc(0)));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hA20, 64'hA24, 0, 0, 0, 1, 2'b01, 0, 64'hA00, 1, 1, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 1, 0, 1, 2'b01, 0, 64'hA00, 0, 0, sc(0)));
        // Clear with a same-cycle double drop: the drop wins
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hA30, 64'hA34, 0, 1, 0, 1, 2'b01, 0, 64'hA00, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 1, 64'hA04, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 0, 64'hA10, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 1, 64'hA14, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 1, 2'b01, 0, 64'hA20, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 1, 2, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 1, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        // NOP sled: four dual-NOP cycles reach 8 on port 1
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 64'h1F4, 64'h1F8, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(2)));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 64'h1FC, 64'h200, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(4)));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 64'h204, 64'h208, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(6)));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 64'h20C, 64'h210, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(8)));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 64'h214, 64'h218, 0, 0, 1, 1'(SL), 2'b10, 1, 64'h210, 0, 0, sc(10)));
        vecs.push_back(mk(2'b01, 2'b00, 2'b00, 64'h300, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        // Flush with two alerts pending and a concurrent JALR
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hC00, 64'hC04, 0, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 0, 1, 2'b01, 0, 64'hC00, 0, 0, sc(0)));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 64'hC10, 64'h0, 1, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        // Flush on a nearly full FIFO: would-be drops are not counted
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hD00, 64'hD04, 0, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hD10, 64'hD14, 0, 0, 0, 1, 2'b01, 0, 64'hD00, 0, 0, sc(0)));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 64'hD20, 64'hD24, 1, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)));

        // Power-on reset
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero(-1);
        rst = 1'b0;

        foreach (vecs[i]) apply_row(vecs[i], i);

        // Asynchronous reset in the middle of a held handshake with overflow set
        apply_row(mk(2'b11, 2'b11, 2'b00, 64'hE00, 64'hE04, 0, 0, 0, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)), 100);
        apply_row(mk(2'b11, 2'b11, 2'b00, 64'hE10, 64'hE14, 0, 0, 0, 1, 2'b01, 0, 64'hE00, 0, 0, sc(0)), 101);
        apply_row(mk(2'b11, 2'b11, 2'b00, 64'hE20, 64'hE24, 0, 0, 0, 1, 2'b01, 0, 64'hE00, 1, 1, sc(0)), 102);
        apply_row(mk(2'b11, 2'b00, 2'b11, 64'hE30, 64'hE34, 0, 0, 0, 1, 2'b01, 0, 64'hE00, 1, 1, sc(2)), 103);
        commit_ack = '0; jalr_det = '0; nop_det = '0; pc = '0;
        alert_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero(104);
        @(posedge clk);
        #1;
        chk_all_zero(105);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            apply_row(mk(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 0, 0, 1, 0, 2'b00, 0, 64'h0, 0, 0, sc(0)), 106 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
